// File: rtl/game_board_pkg.sv
// Shared types and constants for the game board cell store.
package game_board_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_CLEAR
    } state_e;

    // Which source drives wb_dat_r; held between acks so the bus data stays stable.
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_OOR
    } rd_src_e;

    localparam logic [7:0] CELL_OOR   = 8'hFF;
    localparam logic [7:0] CELL_CLEAR = 8'h00;

    typedef struct packed {
        logic       mine;
        logic       revealed;
        logic       flagged;
        logic       rsvd;
        logic [3:0] count;
    } cell_t;

    function automatic logic adr_in_range(input logic [7:0] adr, input logic [4:0] size);
        return ({1'b0, adr[7:4]} < size) && ({1'b0, adr[3:0]} < size);
    endfunction

endpackage

// File: rtl/game_board_ram.sv
// 256-entry cell store: one synchronous write port, one synchronous read port, no reset.
module game_board_ram #(
    parameter int unsigned CELL_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        wr_adr,
    input  logic [CELL_W-1:0] wr_dat,
    input  logic              re,
    input  logic [7:0]        rd_adr,
    output logic [CELL_W-1:0] rd_dat
);

    logic [CELL_W-1:0] mem [256];
    logic [CELL_W-1:0] rd_dat_q;

    // Same-address write forwards the new data so a write ack returns what was stored.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_adr] <= wr_dat;
        end
        if (re) begin
            rd_dat_q <= (we && (wr_adr == rd_adr)) ? wr_dat : mem[rd_adr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/game_board_mem.sv
// Wishbone responder for the game board: range check, single-cycle ack, and 256-cycle wipe.
module game_board_mem
    import game_board_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 16,
    parameter int unsigned CELL_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [7:0]        wb_adr,
    input  logic [CELL_W-1:0] wb_dat_w,
    output logic [CELL_W-1:0] wb_dat_r,
    output logic              wb_ack,
    input  logic [4:0]        board_size,
    input  logic              clear_req,
    output logic              clear_busy
);

    state_e      state_q, state_d;
    rd_src_e     src_q, src_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        clr_pend_q, clr_pend_d;
    logic [7:0]  clr_adr_q, clr_adr_d;

    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_wadr;
    logic [CELL_W-1:0] ram_wdat;
    logic [CELL_W-1:0] ram_rd_dat;
    logic [4:0]        eff_size;
    logic              req;
    logic              hit;

    assign eff_size = (board_size > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : board_size;
    assign req      = wb_cyc & wb_stb;
    assign hit      = adr_in_range(wb_adr, eff_size);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        clr_pend_d = clr_pend_q;
        clr_adr_d  = clr_adr_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_wadr   = wb_adr;
        ram_wdat   = wb_dat_w;

        case (state_q)
            ST_IDLE: begin
                // A wipe takes priority; a concurrent strobe stays pending until it finishes.
                if (clear_req || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_adr_d  = '0;
                    busy_d     = 1'b1;
                    clr_pend_d = 1'b0;
                end else if (req) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (hit) begin
                        src_d  = RD_RAM;
                        ram_re = 1'b1;
                        ram_we = wb_we;
                    end else begin
                        src_d = RD_OOR;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_wadr = clr_adr_q;
                ram_wdat = CELL_W'(CELL_CLEAR);
                if (clr_adr_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_adr_d = clr_adr_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            src_q      <= RD_ZERO;
            ack_q      <= 1'b0;
            busy_q     <= 1'b1;
            clr_pend_q <= 1'b0;
            clr_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            clr_pend_q <= clr_pend_d;
            clr_adr_q  <= clr_adr_d;
        end
    end

    game_board_ram #(
        .CELL_W(CELL_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_adr (ram_wadr),
        .wr_dat (ram_wdat),
        .re     (ram_re),
        .rd_adr (wb_adr),
        .rd_dat (ram_rd_dat)
    );

    always_comb begin
        case (src_q)
            RD_RAM:  wb_dat_r = ram_rd_dat;
            RD_OOR:  wb_dat_r = CELL_W'(CELL_OOR);
            default: wb_dat_r = '0;
        endcase
    end

    assign wb_ack     = ack_q;
    assign clear_busy = busy_q;

endmodule

// File: doc/game_board_mem.md
GAME_BOARD_MEM -- requirements
Module: game_board_mem

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 16; maximum board edge length in cells.
REQ-002 SHALL have parameter CELL_W, default 8; cell data width in bits.
REQ-003 SHALL have port clk, input, 1; the single clock, rising edge; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1; asynchronous active-high reset.
REQ-005 SHALL have port wb_cyc, input, 1; Wishbone bus cycle active.
REQ-006 SHALL have port wb_stb, input, 1; Wishbone strobe.
REQ-007 SHALL have port wb_we, input, 1; 1 = write, 0 = read.
REQ-008 SHALL have port wb_adr, input, 8; {row[7:4], col[3:0]}.
REQ-009 SHALL have port wb_dat_w, input, CELL_W; write data from the master.
REQ-010 SHALL have port wb_dat_r, output, CELL_W; read data to the master.
REQ-011 SHALL have port wb_ack, output, 1; one-cycle acknowledge pulse.
REQ-012 SHALL have port board_size, input, 5; active edge length, 1..MAX_SIZE.
REQ-013 SHALL have port clear_req, input, 1; single-cycle pulse requesting a board wipe.
REQ-014 SHALL have port clear_busy, output, 1; high while a wipe is in progress.
REQ-015 SHALL act as the responder (slave side) of the board bus whose master is the board renderer and game logic, with top level binding these ports to the wishbone_if slave modport.

Function
REQ-016 SHALL implement FSM states IDLE, ACK and CLEAR.
REQ-017 IDLE: SHALL accept a request on wb_cyc & wb_stb sampled at edge N and go to ACK.
REQ-018 ACK: SHALL drive wb_ack=1 for exactly one cycle (N+1), then return to IDLE.
REQ-019 A request still held during ACK SHALL NOT be re-accepted; a held strobe is therefore acked every other cycle.
REQ-020 Read latency SHALL be 1: wb_dat_r SHALL hold the cell value at wb_adr in the same cycle wb_ack=1.
REQ-021 Write: the cell SHALL be updated at edge N; wb_dat_r during ack SHALL be the written value.
REQ-022 A read following a write to the same address SHALL return the new value.
REQ-023 Out-of-range address (row >= board_size or col >= board_size), sampled at edge N: a write SHALL be dropped, a read SHALL return CELL_OOR, and the request SHALL still be acked.
REQ-024 wb_dat_r SHALL hold its last value outside ack cycles.
REQ-025 clear_req in IDLE SHALL enter CLEAR, zeroing one cell per cycle for addresses 0..255 (256 cycles), with clear_busy=1 throughout.
REQ-026 After address 255 is cleared, the FSM SHALL return to IDLE with clear_busy=0.
REQ-027 clear_req together with a strobe in IDLE: clear SHALL win; the request SHALL stay pending and be served after CLEAR.
REQ-028 clear_req during ACK SHALL be latched and CLEAR entered after the ack cycle.
REQ-029 clear_req during CLEAR SHALL be ignored (no restart).
REQ-030 Requests during CLEAR SHALL NOT be acked until CLEAR completes.
REQ-031 A wb_cyc drop during a pending request SHALL abandon the request with no ack.

Reset
REQ-032 On rst=1, state SHALL be CLEAR at clear address 0, with wb_ack=0, wb_dat_r=0, clear_busy=1 and any pending clear flag cleared.
REQ-033 Storage SHALL NOT be reset directly; the post-reset CLEAR sweep SHALL initialise it (256 cycles after rst deasserts).
REQ-034 Reset asserted mid-CLEAR or mid-ACK SHALL restart the sweep from address 0 and drop any ack.

Structure
REQ-035 Package game_board_pkg SHALL hold the FSM state enum, CELL_OOR (8'hFF), the clear value (8'h00) and cell bit fields (mine[7], revealed[6], flagged[5], count[3:0]).
REQ-036 Storage SHALL be sub-module game_board_ram: 256 x CELL_W, with one synchronous write port and one synchronous read port, and no reset.
REQ-037 FSM, range check and clear counter SHALL reside in game_board_mem.

Verification
REQ-038 Reset release: clear_busy SHALL stay high for exactly 256 cycles; a read of adr 8'h35 afterwards SHALL return 8'h00 with ack at N+1.
REQ-039 board_size=16: write 8'h47 to adr 8'h3A, then read adr 8'h3A -> 8'h47; each access SHALL produce a one-cycle ack.
REQ-040 board_size=8: write 8'h11 to adr 8'h09 -> acked and dropped; read adr 8'h09 -> 8'hFF; read adr 8'h77 -> stored value.
REQ-041 Strobe held for 6 cycles: wb_ack SHALL pulse on cycles 2, 4 and 6 only.
REQ-042 clear_req and strobe (read 8'h3A after the 8'h47 write) in the same IDLE cycle: 256 busy cycles, then ack with data 8'h00.
REQ-043 rst pulsed at clear address 100: the sweep SHALL restart and clear_busy SHALL stay high 256 cycles after release.
